// File: rtl/ternary_dmem_arbiter.sv
// Shares the single-port ternary data memory between the CPU data port and a host/DMA port.
// Optional per-grant statistics are enabled by defining TERNARY_ARB_STATS_EN.
module ternary_dmem_arbiter #(
  parameter int TRIT_WIDTH = 27,
  parameter int ADDR_TRITS = 9,
  parameter int MAX_WAIT   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*ADDR_TRITS-1:0]   cpu_addr,
  input  logic [2*TRIT_WIDTH-1:0]   cpu_wdata,
  input  logic                      cpu_we,
  input  logic                      cpu_re,
  output logic [2*TRIT_WIDTH-1:0]   cpu_rdata,
  output logic                      cpu_hold,
  input  logic                      host_req,
  input  logic                      host_we,
  input  logic [2*ADDR_TRITS-1:0]   host_addr,
  input  logic [2*TRIT_WIDTH-1:0]   host_wdata,
  output logic                      host_ack,
  output logic [2*TRIT_WIDTH-1:0]   host_rdata,
  output logic [2*ADDR_TRITS-1:0]   mem_addr,
  output logic [2*TRIT_WIDTH-1:0]   mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [2*TRIT_WIDTH-1:0]   mem_rdata,
  output logic                      grant_host
`ifdef TERNARY_ARB_STATS_EN
  ,
  output logic [15:0]               stat_grants,
  output logic [15:0]               stat_forces
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FORCE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  localparam logic [1:0] T_ZERO    = 2'b00;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       cpu_active;
  logic       sel_host;

  assign cpu_active = cpu_we | cpu_re;
  assign sel_host   = (state == FORCE) | ((state == IDLE) & host_req & ~cpu_active);
  assign grant_host = sel_host;

  // Decoded from the state register alone so the core sees glitch-free control.
  assign cpu_hold = (state == FORCE);
  assign host_ack = (state == ACK);

  always_comb begin
    if (sel_host) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
      mem_re    = ~host_we;
      cpu_rdata = {TRIT_WIDTH{T_ZERO}};
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = cpu_re;
      cpu_rdata = mem_rdata;
    end
  end

  // wait_cnt holds at MAX_WAIT-1 on the FORCE transition and is cleared by the grant.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (sel_host) begin
          wait_nxt  = 8'd0;
          state_nxt = ACK;
        end else if (host_req && cpu_active) begin
          if (wait_cnt == WAIT_LAST) state_nxt = FORCE;
          else                       wait_nxt  = wait_cnt + 8'd1;
        end else if (!host_req) begin
          wait_nxt = 8'd0;
        end
      end
      FORCE: begin
        wait_nxt  = 8'd0;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      host_rdata <= {TRIT_WIDTH{T_ZERO}};
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (sel_host && !host_we) host_rdata <= mem_rdata;
    end
  end

`ifdef TERNARY_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= 16'd0;
      stat_forces <= 16'd0;
    end else begin
      if (sel_host && stat_grants != 16'hFFFF) stat_grants <= stat_grants + 16'd1;
      if (state == IDLE && state_nxt == FORCE && stat_forces != 16'hFFFF)
        stat_forces <= stat_forces + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ternary_dmem_arbiter.sv
// Randomized scoreboard bench for ternary_dmem_arbiter; host grants are predicted from
// the blocked-cycle count and read data from a shadow copy of memory.
module tb_ternary_dmem_arbiter;
  localparam int TW = 27;
  localparam int AT = 9;
  localparam int MW = 8;
  localparam int DW = 2 * TW;
  localparam int AW = 2 * AT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cpu_addr, host_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic          cpu_we, cpu_re, cpu_hold, host_req, host_we, host_ack;
  logic          mem_we, mem_re, grant_host;
`ifdef TERNARY_ARB_STATS_EN
  logic [15:0]   stat_grants, stat_forces;
`endif

  ternary_dmem_arbiter #(.TRIT_WIDTH(TW), .ADDR_TRITS(AT), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .grant_host(grant_host)
`ifdef TERNARY_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_forces(stat_forces)
`endif
  );

  always #5 clk = ~clk;

  // Memory macro stand-in: combinational read, write on the clock edge.
  logic [DW-1:0] mem_array [0:255];
  logic [DW-1:0] shadow    [0:255];
  always @(posedge clk) if (mem_we) mem_array[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem_array[mem_addr[7:0]];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int fails  = 0;
  typedef struct packed { logic [31:0] cyc; logic [DW-1:0] rdata; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] last_read;
  int            exp_grants = 0;
  int            exp_forces = 0;

  function automatic logic [DW-1:0] to_trits(input int v);
    logic [DW-1:0] r = '0;
    int x = v;
    int m;
    for (int i = 0; i < TW; i++) begin
      m = ((x % 3) + 3) % 3;
      if (m == 1)      begin r[2*i +: 2] = 2'b01; x = (x - 1) / 3; end
      else if (m == 2) begin r[2*i +: 2] = 2'b10; x = (x + 1) / 3; end
      else             x = x / 3;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int v);
    logic [DW-1:0] t = to_trits(v);
    return t[AW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic cwe, input logic cre, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cd, input logic hreq, input logic hwe,
                               input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    cpu_we = cwe; cpu_re = cre; cpu_addr = ca; cpu_wdata = cd;
    host_req = hreq; host_we = hwe; host_addr = ha; host_wdata = hd;
  endtask

  // One clock: drive, check the combinational mux at the falling edge, update the model.
  task automatic cycle_step(input logic cwe, input logic cre, input logic [AW-1:0] ca,
                            input logic [DW-1:0] cd, input logic hreq, input logic hwe,
                            input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                            input logic exp_grant, input logic exp_hold);
    applyStimulus(cwe, cre, ca, cd, hreq, hwe, ha, hd);
    @(negedge clk);
    checkOutput("grant_host", grant_host, exp_grant);
    checkOutput("cpu_hold", cpu_hold, exp_hold);
    checkOutput("mem_addr", mem_addr, exp_grant ? ha : ca);
    checkOutput("mem_wdata", mem_wdata, exp_grant ? hd : cd);
    checkOutput("mem_we", mem_we, exp_grant ? hwe : cwe);
    checkOutput("mem_re", mem_re, exp_grant ? !hwe : cre);
    checkOutput("cpu_rdata", cpu_rdata, exp_grant ? '0 : shadow[ca[7:0]]);
    if (exp_grant && hwe) shadow[ha[7:0]] = hd;
    if (!exp_grant && cwe) shadow[ca[7:0]] = cd;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cpu(input bit must_active, output logic we, output logic re,
                          output logic [AW-1:0] a, output logic [DW-1:0] d);
    int op = must_active ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
    we = (op == 1);
    re = (op == 2);
    a  = addr_of(int'($urandom_range(0, 80)) - 40);
    d  = to_trits(int'($urandom_range(0, 2000000)) - 1000000);
  endtask

  // A host access granted after min(busy, MW) cycles; forced when the CPU is busy MW or more.
  task automatic host_txn(input logic hwe, input int av, input int dv, input int busy, input int gap);
    logic [AW-1:0] ha = addr_of(av);
    logic [DW-1:0] hd = to_trits(dv);
    int  gk = (busy < MW) ? busy : MW;
    bit  forced = (busy >= MW);
    logic cwe, cre;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    for (int k = 0; k < gk; k++) begin
      rand_cpu(1'b1, cwe, cre, ca, cd);
      cycle_step(cwe, cre, ca, cd, 1'b1, hwe, ha, hd, 1'b0, 1'b0);
    end
    rand_cpu(forced, cwe, cre, ca, cd);
    if (!forced) begin cwe = 1'b0; cre = 1'b0; end
    if (!hwe) last_read = shadow[ha[7:0]];
    sb.push_back('{cyc: 32'(cycle + 1), rdata: last_read});
    exp_grants++;
    if (forced) exp_forces++;
    cycle_step(cwe, cre, ca, cd, 1'b1, hwe, ha, hd, 1'b1, forced);
    rand_cpu(1'b0, cwe, cre, ca, cd);
    cycle_step(cwe, cre, ca, cd, 1'b1, hwe, ha, hd, 1'b0, 1'b0);
    for (int g = 0; g < gap; g++) begin
      rand_cpu(1'b0, cwe, cre, ca, cd);
      cycle_step(cwe, cre, ca, cd, 1'b0, hwe, ha, hd, 1'b0, 1'b0);
    end
  endtask

  // Scoreboard monitor: every host_ack must match the oldest predicted completion.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && int'(sb[0].cyc) == cycle) begin
        checkOutput("host_ack", host_ack, 1'b1);
        if (host_ack) checkOutput("host_rdata", host_rdata, sb[0].rdata);
        void'(sb.pop_front());
      end else if (host_ack) begin
        checkOutput("host_ack_unexpected", host_ack, 1'b0);
      end
    end
  end

  initial begin
    logic cwe, cre;
    logic [AW-1:0] ca, ha;
    logic [DW-1:0] cd;
    for (int i = 0; i < 256; i++) begin mem_array[i] = '0; shadow[i] = '0; end
    last_read = '0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_host_ack", host_ack, 1'b0);
    checkOutput("reset_cpu_hold", cpu_hold, 1'b0);
    checkOutput("reset_grant_host", grant_host, 1'b0);
    checkOutput("reset_host_rdata", host_rdata, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    host_txn(1'b1, 4, 13, 0, 1);
    host_txn(1'b0, 4, 0, 0, 1);
    checkOutput("host_rdata_plus13", host_rdata, to_trits(13));
    host_txn(1'b0, 7, 0, 3, 0);
    host_txn(1'b1, -5, 777, MW + 4, 2);
    host_txn(1'b0, -5, 0, MW, 1);
    host_txn(1'b0, 9, 0, MW - 1, 1);

    // Withdrawn request: the wait count restarts, so the next request needs MW blocked cycles.
    ha = addr_of(11);
    for (int k = 0; k < 5; k++) begin
      rand_cpu(1'b1, cwe, cre, ca, cd);
      cycle_step(cwe, cre, ca, cd, 1'b1, 1'b0, ha, '0, 1'b0, 1'b0);
    end
    rand_cpu(1'b1, cwe, cre, ca, cd);
    cycle_step(cwe, cre, ca, cd, 1'b0, 1'b0, ha, '0, 1'b0, 1'b0);
    host_txn(1'b0, 11, 0, MW + 1, 0);
    host_txn(1'b1, 12, -99, 0, 0);
    host_txn(1'b0, 12, 0, 0, 0);

    // Asynchronous reset while the CPU is frozen in a forced host cycle.
    for (int k = 0; k < MW; k++) begin
      rand_cpu(1'b1, cwe, cre, ca, cd);
      cycle_step(cwe, cre, ca, cd, 1'b1, 1'b0, ha, '0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, ca, cd, 1'b1, 1'b0, ha, '0);
    #2;
    checkOutput("force_cpu_hold", cpu_hold, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("areset_cpu_hold", cpu_hold, 1'b0);
    checkOutput("areset_host_ack", host_ack, 1'b0);
    checkOutput("areset_grant_host", grant_host, 1'b0);
    checkOutput("areset_host_rdata", host_rdata, '0);
    last_read  = '0;
    exp_grants = 0;
    exp_forces = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;

    repeat (150) begin
      host_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 80)) - 40,
               int'($urandom_range(0, 2000000)) - 1000000,
               int'($urandom_range(0, MW + 2)), int'($urandom_range(0, 2)));
    end

    repeat (3) begin
      rand_cpu(1'b0, cwe, cre, ca, cd);
      cycle_step(cwe, cre, ca, cd, 1'b0, 1'b0, ha, '0, 1'b0, 1'b0);
    end
`ifdef TERNARY_ARB_STATS_EN
    checkOutput("stat_grants", stat_grants, 16'(exp_grants));
    checkOutput("stat_forces", stat_forces, 16'(exp_forces));
`endif
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
